// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush control for a 5-stage pipeline with a multi-cycle mul/div unit.
module pipeline_hazard_ctrl (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  ID_RS1_ADDR,
    input  logic [4:0]  ID_RS2_ADDR,
    input  logic        ID_RS1_USED,
    input  logic        ID_RS2_USED,
    input  logic        EX_VALID,
    input  logic [4:0]  EX_RD_ADDR,
    input  logic        EX_IS_LOAD,
    input  logic        EX_IS_MUL,
    input  logic        EX_IS_DIV,
    input  logic        BRANCH_TAKEN,
    input  logic        ICACHE_BUSY,
    input  logic        DCACHE_BUSY,
    output logic        PC_STALL,
    output logic        IF_ID_STALL,
    output logic        ID_EX_STALL,
    output logic        EX_MEM_STALL,
    output logic        MEM_WB_STALL,
    output logic        IF_ID_FLUSH,
    output logic        ID_EX_FLUSH,
    output logic        EX_MEM_FLUSH,
    output logic        MULDIV_BUSY,
    output logic        MULDIV_DONE,
    output logic [31:0] STALL_COUNT
);
    typedef enum logic {RUN, MULDIV} state_t;
    state_t     state;
    logic [5:0] md_cnt;
    logic       md_done_q;
    logic       in_md, md_start, md_exit, load_use, free, dc_act, md_act, br_act, lu_act, ic_act;

    assign in_md    = state == MULDIV;
    // md_done_q blocks re-entry while EX_MEM captures the finished result
    assign md_start = state == RUN && EX_VALID && (EX_IS_MUL || EX_IS_DIV) && !md_done_q && !DCACHE_BUSY;
    assign md_exit  = in_md && md_cnt == 6'd1 && !DCACHE_BUSY;
    assign load_use = EX_VALID && EX_IS_LOAD && EX_RD_ADDR != 5'd0 &&
                      ((ID_RS1_USED && ID_RS1_ADDR == EX_RD_ADDR) || (ID_RS2_USED && ID_RS2_ADDR == EX_RD_ADDR));

    assign free   = !RESET && !DCACHE_BUSY;
    assign dc_act = !RESET && DCACHE_BUSY;
    assign md_act = free && (in_md || md_start);
    assign br_act = free && !(in_md || md_start) && BRANCH_TAKEN;
    assign lu_act = free && !(in_md || md_start) && !BRANCH_TAKEN && load_use;
    assign ic_act = free && !(in_md || md_start) && !BRANCH_TAKEN && !load_use && ICACHE_BUSY;

    assign PC_STALL     = dc_act || md_act || lu_act || ic_act;
    assign IF_ID_STALL  = dc_act || md_act || lu_act;
    assign ID_EX_STALL  = dc_act || md_act;
    assign EX_MEM_STALL = dc_act;
    assign MEM_WB_STALL = dc_act;
    assign IF_ID_FLUSH  = RESET || br_act || ic_act;
    assign ID_EX_FLUSH  = RESET || br_act || lu_act;
    assign EX_MEM_FLUSH = RESET || md_act;
    assign MULDIV_BUSY  = !RESET && (in_md || md_act);
    assign MULDIV_DONE  = !RESET && md_exit;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= RUN;
            md_cnt      <= '0;
            md_done_q   <= 1'b0;
            STALL_COUNT <= '0;
        end else begin
            if (PC_STALL && STALL_COUNT != '1) STALL_COUNT <= STALL_COUNT + 32'd1;
            md_done_q <= md_exit || (DCACHE_BUSY && md_done_q);
            if (md_start) begin
                state  <= MULDIV;
                md_cnt <= EX_IS_DIV ? 6'd33 : 6'd2;
            end else if (in_md) begin
                state  <= md_exit ? RUN : MULDIV;
                // the unit keeps running under a dcache stall but parks on its last cycle
                md_cnt <= (md_cnt == 6'd1) ? (DCACHE_BUSY ? 6'd1 : 6'd0) : md_cnt - 6'd1;
            end
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed and random checks of pipeline_hazard_ctrl
// against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;
    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [4:0]  ID_RS1_ADDR = '0, ID_RS2_ADDR = '0, EX_RD_ADDR = '0;
    logic        ID_RS1_USED = 1'b0, ID_RS2_USED = 1'b0, EX_VALID = 1'b0;
    logic        EX_IS_LOAD = 1'b0, EX_IS_MUL = 1'b0, EX_IS_DIV = 1'b0;
    logic        BRANCH_TAKEN = 1'b0, ICACHE_BUSY = 1'b0, DCACHE_BUSY = 1'b0;
    logic        PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL, MEM_WB_STALL;
    logic        IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MULDIV_BUSY, MULDIV_DONE;
    logic [31:0] STALL_COUNT;

    pipeline_hazard_ctrl dut (
        .CLK(CLK), .RESET(RESET),
        .ID_RS1_ADDR(ID_RS1_ADDR), .ID_RS2_ADDR(ID_RS2_ADDR),
        .ID_RS1_USED(ID_RS1_USED), .ID_RS2_USED(ID_RS2_USED),
        .EX_VALID(EX_VALID), .EX_RD_ADDR(EX_RD_ADDR), .EX_IS_LOAD(EX_IS_LOAD),
        .EX_IS_MUL(EX_IS_MUL), .EX_IS_DIV(EX_IS_DIV), .BRANCH_TAKEN(BRANCH_TAKEN),
        .ICACHE_BUSY(ICACHE_BUSY), .DCACHE_BUSY(DCACHE_BUSY),
        .PC_STALL(PC_STALL), .IF_ID_STALL(IF_ID_STALL), .ID_EX_STALL(ID_EX_STALL),
        .EX_MEM_STALL(EX_MEM_STALL), .MEM_WB_STALL(MEM_WB_STALL),
        .IF_ID_FLUSH(IF_ID_FLUSH), .ID_EX_FLUSH(ID_EX_FLUSH), .EX_MEM_FLUSH(EX_MEM_FLUSH),
        .MULDIV_BUSY(MULDIV_BUSY), .MULDIV_DONE(MULDIV_DONE), .STALL_COUNT(STALL_COUNT)
    );

    always #5 CLK = ~CLK;

    int          vectors = 0, miscompares = 0;
    int          cyc = 0, done_cyc = -1, busy_seen = 0, done_seen = 0, t0 = 0;
    // model: remaining unit cycles (0 = unit idle), capture cycle flag, stall counter
    int          m_left = 0;
    logic        m_capture = 1'b0, m_known = 1'b0;
    logic [31:0] m_count = '0;

    function automatic logic lu_hazard();
        return EX_VALID && EX_IS_LOAD && EX_RD_ADDR != 5'd0 &&
               ((ID_RS1_USED && ID_RS1_ADDR == EX_RD_ADDR) || (ID_RS2_USED && ID_RS2_ADDR == EX_RD_ADDR));
    endfunction

    function automatic logic unit_go();
        return m_left == 0 && EX_VALID && (EX_IS_MUL || EX_IS_DIV) && !m_capture && !DCACHE_BUSY;
    endfunction

    // {PC, IF_ID, ID_EX, EX_MEM, MEM_WB stalls, IF_ID, ID_EX, EX_MEM flushes, BUSY, DONE}
    function automatic logic [9:0] exp_flags();
        logic md;
        md = m_left > 0;
        if (RESET) return 10'b00000_111_00;
        if (DCACHE_BUSY) return {8'b11111_000, md, 1'b0};
        if (md || unit_go()) return {8'b11100_001, 1'b1, md && m_left == 1};
        if (BRANCH_TAKEN) return 10'b00000_110_00;
        if (lu_hazard()) return 10'b11000_010_00;
        if (ICACHE_BUSY) return 10'b10000_100_00;
        return '0;
    endfunction

    task automatic model_edge(input logic pc_stall);
        if (RESET) begin
            m_left = 0;
            m_capture = 1'b0;
            m_count = '0;
            m_known = 1'b1;
        end else begin
            if (pc_stall && m_count != 32'hFFFF_FFFF) m_count = m_count + 32'd1;
            if (m_left > 0) begin
                if (m_left == 1 && !DCACHE_BUSY) begin
                    m_left = 0;
                    m_capture = 1'b1;
                end else m_left = (m_left > 1) ? m_left - 1 : 1;
            end else begin
                if (unit_go()) m_left = EX_IS_DIV ? 34 - 1 : 3 - 1;
                m_capture = DCACHE_BUSY && m_capture;
            end
        end
    endtask

    task automatic step(input string tag);
        logic [9:0] e, g;
        #1;
        e = exp_flags();
        g = {PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL, MEM_WB_STALL,
             IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH, MULDIV_BUSY, MULDIV_DONE};
        vectors++;
        assert (g === e) else begin
            miscompares++;
            $error("FAIL %s flags cyc=%0d observed=%b expected=%b", tag, cyc, g, e);
        end
        if (m_known) begin
            vectors++;
            assert (STALL_COUNT === m_count) else begin
                miscompares++;
                $error("FAIL %s stall_count cyc=%0d observed=%0d expected=%0d", tag, cyc, STALL_COUNT, m_count);
            end
        end
        if (MULDIV_BUSY === 1'b1) busy_seen++;
        if (MULDIV_DONE === 1'b1) begin
            done_seen++;
            done_cyc = cyc;
        end
        cyc++;
        @(posedge CLK);
        model_edge(e[9]);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        {ID_RS1_ADDR, ID_RS2_ADDR, EX_RD_ADDR} = '0;
        {ID_RS1_USED, ID_RS2_USED, EX_VALID, EX_IS_LOAD, EX_IS_MUL, EX_IS_DIV} = '0;
        {BRANCH_TAKEN, ICACHE_BUSY, DCACHE_BUSY} = '0;
    endtask

    task automatic do_reset();
        idle();
        RESET = 1'b1;
        step("reset");
        RESET = 1'b0;
    endtask

    initial begin
        RESET = 1'b1;
        step("reset0");
        step("reset1");
        chk("reset_count", STALL_COUNT, 0);
        RESET = 1'b0;
        step("idle");
        // load-use through rs2
        EX_VALID = 1'b1; EX_IS_LOAD = 1'b1; EX_RD_ADDR = 5'd5;
        ID_RS2_ADDR = 5'd5; ID_RS2_USED = 1'b1; ID_RS1_ADDR = 5'd7; ID_RS1_USED = 1'b1;
        step("load_use");
        chk("lu_pc_stall_seen", {31'd0, m_count == 32'd1}, 1);
        idle();
        step("lu_bubble");
        chk("lu_count", STALL_COUNT, 1);
        // load to x0 never hazards
        EX_VALID = 1'b1; EX_IS_LOAD = 1'b1; EX_RD_ADDR = 5'd0; ID_RS1_ADDR = 5'd0; ID_RS1_USED = 1'b1;
        step("load_x0");
        chk("x0_count", STALL_COUNT, 1);
        // unused source field ignored
        EX_RD_ADDR = 5'd9; ID_RS2_ADDR = 5'd9; ID_RS2_USED = 1'b0; ID_RS1_ADDR = 5'd3;
        step("unused_src");
        // branch overrides load-use and icache
        EX_RD_ADDR = 5'd5; ID_RS2_ADDR = 5'd5; ID_RS2_USED = 1'b1; BRANCH_TAKEN = 1'b1; ICACHE_BUSY = 1'b1;
        step("branch_vs_lu");
        chk("branch_count", STALL_COUNT, 1);
        idle();
        ICACHE_BUSY = 1'b1;
        step("icache");
        // DIV: busy 34 cycles, done on the 34th, then a capture cycle without re-entry
        do_reset();
        busy_seen = 0; done_seen = 0; t0 = cyc;
        EX_VALID = 1'b1; EX_IS_DIV = 1'b1;
        for (int i = 0; i < 35; i++) step("div");
        chk("div_busy", 32'(busy_seen), 34);
        chk("div_done_cnt", 32'(done_seen), 1);
        chk("div_done_at", 32'(done_cyc - t0), 33);
        chk("div_count", STALL_COUNT, 34);
        idle();
        step("div_after");
        // MUL stretched by a 5-cycle dcache stall
        do_reset();
        done_seen = 0;
        EX_VALID = 1'b1; EX_IS_MUL = 1'b1;
        step("mul_entry");
        DCACHE_BUSY = 1'b1;
        for (int i = 0; i < 5; i++) step("mul_dc");
        chk("mul_no_early_done", 32'(done_seen), 0);
        DCACHE_BUSY = 1'b0; t0 = cyc;
        step("mul_exit");
        step("mul_capture");
        idle();
        for (int i = 0; i < 3; i++) step("mul_tail");
        chk("mul_done_cnt", 32'(done_seen), 1);
        chk("mul_done_at", 32'(done_cyc), 32'(t0));
        // reset aborts DIV
        do_reset();
        done_seen = 0;
        EX_VALID = 1'b1; EX_IS_DIV = 1'b1;
        for (int i = 0; i < 10; i++) step("div_abort");
        RESET = 1'b1;
        step("abort_reset");
        RESET = 1'b0;
        idle();
        chk("abort_count", STALL_COUNT, 0);
        step("abort_run");
        chk("abort_done", 32'(done_seen), 0);
        chk("abort_busy", {31'd0, MULDIV_BUSY}, 0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            RESET        = $urandom_range(0, 299) == 0;
            DCACHE_BUSY  = $urandom_range(0, 5) == 0;
            ICACHE_BUSY  = $urandom_range(0, 3) == 0;
            BRANCH_TAKEN = $urandom_range(0, 5) == 0;
            EX_VALID     = $urandom_range(0, 3) != 0;
            EX_IS_LOAD   = $urandom_range(0, 2) == 0;
            EX_IS_MUL    = $urandom_range(0, 11) == 0;
            EX_IS_DIV    = $urandom_range(0, 29) == 0;
            EX_RD_ADDR   = 5'($urandom_range(0, 3));
            ID_RS1_ADDR  = 5'($urandom_range(0, 3));
            ID_RS2_ADDR  = 5'($urandom_range(0, 3));
            ID_RS1_USED  = 1'($urandom_range(0, 1));
            ID_RS2_USED  = 1'($urandom_range(0, 1));
            step("random");
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
